bid_credit_scheduler: RTL and testbench
=======================================

// Module: bid_credit_scheduler
// PURPOSE
//   Shares one downstream resource among N_REQ masters. Each master requests with a bid.
//   The highest eligible bid wins. Ties are broken round-robin.
//   Each grant is held until the owner signals done, then the bid is charged against that
//   master's credit bank. Banks are replenished every EPOCH_LEN cycles.
//   Sits between the master request ports and the shared resource mux select.
// PARAMETERS
//   N_REQ        4    number of requesters (2..8)
//   BID_W        4    bid width per requester
//   CREDIT_W     10   credit bank width
//   CREDIT_INIT  750  bank value at reset and per-epoch top-up amount
//   CREDIT_MAX   900  bank saturation ceiling
//   EPOCH_LEN    400  cycles per replenish epoch
//   MAX_HOLD     16   max cycles a grant is held without done
//   STARVE_LIM   60   wait cycles before forced service (STARVE_GUARD_EN only)
// PORTS
//   clk      in   1            clock, rising edge
//   rst      in   1            reset, asynchronous, active-high
//   req      in   N_REQ        per-master request, level
//   bid      in   N_REQ*BID_W  packed bids; master i at [i*BID_W +: BID_W]
//   done     in   1            owner releases resource (1-cycle pulse)
//   gnt      out  N_REQ        one-hot grant, registered
//   gnt_id   out  $clog2(N_REQ) index of current owner; valid while |gnt
//   busy     out  1            1 in GRANT or RELEASE
// BEHAVIOUR
//   Reset (async): gnt=0, gnt_id=0, busy=0, state=IDLE, all banks=CREDIT_INIT,
//     epoch counter=0, rr pointer=0, hold/starve counters=0.
//   Eligible(i) = req[i] && bid[i]!=0 && credit[i]>=bid[i].
//   FSM:
//     IDLE    -> GRANT if any master eligible. Winner chosen combinationally; gnt is
//                registered, so gnt asserts 1 cycle after req is sampled.
//     GRANT   gnt held stable and bid[owner] latched at grant time.
//             Exit to RELEASE on done, on req[owner] low, or when hold count reaches MAX_HOLD.
//     RELEASE gnt=0 for exactly 1 cycle. Charge: credit -= latched bid, floored at 0.
//             Then -> IDLE.
//   done outside GRANT is ignored.
//   Winner: largest bid among eligible masters. Equal maxima go to the first index
//     at or after rr_ptr. On each grant, rr_ptr = winner+1 mod N_REQ.
//   Epoch: counter runs 0..EPOCH_LEN-1 and wraps. On wrap, every bank becomes
//     min(credit+CREDIT_INIT, CREDIT_MAX).
//   Charge and replenish in the same cycle: charge first, then top-up, then saturate.
//   All bank arithmetic uses CREDIT_W+1 bits internally; there is no wrap-around.
// CONFIGURATION
//   STARVE_GUARD_EN defined: per-master counter increments while req[i] && !gnt[i],
//     and clears on grant or when req[i] is low. The counter saturates at STARVE_LIM.
//     Any master at STARVE_LIM wins the next IDLE arbitration regardless of bid or credit.
//     If several masters are starved, the lowest index wins. A bid of 0 is charged as 0.
//   Not defined: no starvation counters; the pure bid/credit policy above applies.
// STRUCTURE
//   arb_pkg: state enum {IDLE,GRANT,RELEASE}; default parameter constants;
//     function pick_winner(bids, elig, rr_ptr).
//   Sub-module credit_bank (one per master): holds the bank and applies the
//     charge/top-up/saturate rules; exposes credit to the scheduler for the
//     eligibility check.
// TESTING
//   1. req=4'b0011, bids 5/9, done after 3 cycles -> gnt=0010 one cycle later;
//      bank1=741 after RELEASE.
//   2. Equal bids 7 on all 4 masters, repeated grants -> gnt order
//      0001,0010,0100,1000,0001.
//   3. Master 0 bid 15, repeated grants -> bank0 goes 750->735->...; when bank0 < 15
//      it becomes ineligible; at epoch wrap it refills to min(bank0+750, 900).
//   4. Done never asserted -> gnt drops after 16 cycles, RELEASE lasts 1 cycle,
//      and the bid is charged.
//   5. STARVE_GUARD_EN: master 3 bid 1 vs master 0 bid 15 continuously ->
//      gnt=1000 after 60 wait cycles.
//   6. rst asserted mid-GRANT -> gnt=0 immediately; banks=750; first grant after
//      rst falls follows rr_ptr=0.

Source files
------------

// File: rtl/bid_credit_scheduler_pkg.sv
// Shared constants and the bid arbitration helper for bid_credit_scheduler.
// Holds the default parameter values, the FSM state encodings and pick_winner(),
// which selects the highest eligible bid with round-robin tie-breaking.
package bid_credit_scheduler_pkg;

    // Default configuration values
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_BID_W       = 4;
    localparam int DEF_CREDIT_W    = 10;
    localparam int DEF_CREDIT_INIT = 750;
    localparam int DEF_CREDIT_MAX  = 900;
    localparam int DEF_EPOCH_LEN   = 400;
    localparam int DEF_MAX_HOLD    = 16;
    localparam int DEF_STARVE_LIM  = 60;

    // pick_winner works on fixed-size vectors; callers zero-pad up to these limits
    localparam int MAX_REQ   = 8;
    localparam int MAX_BID_W = 16;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Highest bid among eligible masters; on equal maxima the first index at or
    // after rr_ptr (circularly over n_req entries) wins. Scanning in rotated order
    // and replacing only on a strictly larger bid gives exactly that tie rule.
    // The result is meaningless when no entry of elig is set.
    function automatic logic [2:0] pick_winner(
        input logic [MAX_REQ-1:0][MAX_BID_W-1:0] bids,
        input logic [MAX_REQ-1:0]                elig,
        input logic [2:0]                        rr_ptr,
        input logic [3:0]                        n_req
    );
        logic [2:0]           win;
        logic [MAX_BID_W-1:0] best;
        logic                 found;
        logic [3:0]           idx;
        win   = '0;
        best  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            if ((4'(k) < n_req) && elig[idx[2:0]] &&
                (!found || (bids[idx[2:0]] > best))) begin
                win   = idx[2:0];
                best  = bids[idx[2:0]];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bid_credit_scheduler_credit_bank.sv
// One master's credit bank. Applies, in order within one cycle: the charge of a
// completed grant (floored at zero), the per-epoch top-up, then saturation at
// CREDIT_MAX. Arithmetic is one bit wider than the bank so nothing wraps.
module bid_credit_scheduler_credit_bank #(
    parameter int BID_W       = 4,
    parameter int CREDIT_W    = 10,
    parameter int CREDIT_INIT = 750,
    parameter int CREDIT_MAX  = 900
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                charge_en,
    input  logic [BID_W-1:0]    charge_amt,
    input  logic                topup_en,
    output logic [CREDIT_W-1:0] credit
);

    localparam int EXT_W = CREDIT_W + 1;
    localparam logic [EXT_W-1:0]    INIT_EXT = EXT_W'(CREDIT_INIT);
    localparam logic [EXT_W-1:0]    MAX_EXT  = EXT_W'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0] MAX_C    = CREDIT_W'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0] INIT_C   = CREDIT_W'(CREDIT_INIT);

    logic [CREDIT_W-1:0] bank_q, bank_d;
    logic [EXT_W-1:0]    bank_ext, amt_ext, after_charge, after_topup;

    // Next bank value: charge, then top-up, then clamp to the ceiling
    always_comb begin
        bank_ext     = {1'b0, bank_q};
        amt_ext      = EXT_W'(charge_amt);
        after_charge = bank_ext;
        if (charge_en) begin
            after_charge = (bank_ext >= amt_ext) ? (bank_ext - amt_ext) : '0;
        end
        after_topup = topup_en ? (after_charge + INIT_EXT) : after_charge;
        bank_d      = (after_topup > MAX_EXT) ? MAX_C : after_topup[CREDIT_W-1:0];
    end

    // Bank register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= INIT_C;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign credit = bank_q;

endmodule

// File: rtl/bid_credit_scheduler.sv
// Bid/credit arbiter for one shared resource among N_REQ masters.
// IDLE picks the highest eligible bid (round-robin on ties) and registers a
// one-hot grant; GRANT holds it until done, owner request drop or MAX_HOLD
// cycles; RELEASE idles gnt for one cycle while the latched bid is charged.
// Banks are topped up every EPOCH_LEN cycles.
// Optional macro STARVE_GUARD_EN: masters waiting STARVE_LIM cycles are forced
// through at the next IDLE arbitration (lowest starved index first).
module bid_credit_scheduler
    import bid_credit_scheduler_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int BID_W       = DEF_BID_W,
    parameter int CREDIT_W    = DEF_CREDIT_W,
    parameter int CREDIT_INIT = DEF_CREDIT_INIT,
    parameter int CREDIT_MAX  = DEF_CREDIT_MAX,
    parameter int EPOCH_LEN   = DEF_EPOCH_LEN,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int STARVE_LIM  = DEF_STARVE_LIM,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BID_W-1:0] bid,
    input  logic                   done,
    output logic [N_REQ-1:0]       gnt,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   busy
);

    localparam int EXT_W  = CREDIT_W + 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int EP_W   = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    // Registered state
    logic [1:0]        state_q,  state_d;
    logic [N_REQ-1:0]  gnt_q,    gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [BID_W-1:0]  bid_lat_q, bid_lat_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [EP_W-1:0]   epoch_q,  epoch_d;

    // Per-master views
    logic [BID_W-1:0]                 bid_arr [N_REQ];
    logic [N_REQ-1:0][CREDIT_W-1:0]   credit_all;
    logic [N_REQ-1:0]                 elig;
    logic [N_REQ-1:0]                 charge_en;
    logic [MAX_REQ-1:0][MAX_BID_W-1:0] bids_ext;
    logic [MAX_REQ-1:0]               elig_ext;

    // Arbitration result
    logic [ID_W-1:0] win_idx;
    logic            sel_valid;
    logic [ID_W-1:0] sel_idx;
    logic            epoch_wrap;

    genvar gi;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_master
            assign bid_arr[gi]   = bid[gi*BID_W +: BID_W];
            assign elig[gi]      = req[gi] && (bid_arr[gi] != '0) &&
                                   (EXT_W'(credit_all[gi]) >= EXT_W'(bid_arr[gi]));
            assign charge_en[gi] = (state_q == ST_RELEASE) && (gnt_id_q == ID_W'(gi));

            bid_credit_scheduler_credit_bank #(
                .BID_W       (BID_W),
                .CREDIT_W    (CREDIT_W),
                .CREDIT_INIT (CREDIT_INIT),
                .CREDIT_MAX  (CREDIT_MAX)
            ) u_bank (
                .clk        (clk),
                .rst        (rst),
                .charge_en  (charge_en[gi]),
                .charge_amt (bid_lat_q),
                .topup_en   (epoch_wrap),
                .credit     (credit_all[gi])
            );
        end

        // Pad the arbitration inputs out to the helper's fixed width
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_pad
            if (gi < N_REQ) begin : g_used
                assign bids_ext[gi] = MAX_BID_W'(bid_arr[gi]);
                assign elig_ext[gi] = elig[gi];
            end else begin : g_unused
                assign bids_ext[gi] = '0;
                assign elig_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign win_idx    = ID_W'(pick_winner(bids_ext, elig_ext, 3'(rr_ptr_q), 4'(N_REQ)));
    assign epoch_wrap = (epoch_q == EP_W'(EPOCH_LEN - 1));

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0]    starve_q [N_REQ];
    logic [SW-1:0]    starve_d [N_REQ];
    logic [N_REQ-1:0] starved;
    logic [N_REQ-1:0] grant_now;
    logic             forced_any;
    logic [ID_W-1:0]  forced_idx;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_starve
            assign starved[gi]   = req[gi] && (starve_q[gi] == SW'(STARVE_LIM));
            assign grant_now[gi] = (state_q == ST_IDLE) && sel_valid && (sel_idx == ID_W'(gi));
        end
    endgenerate

    // Lowest starved index overrides the bid contest
    always_comb begin
        forced_any = |starved;
        forced_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (starved[i]) begin
                forced_idx = ID_W'(i);
            end
        end
    end

    // Wait counters: count while requesting without the grant, saturate, clear otherwise
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starve_d[i] = starve_q[i];
            if (!req[i] || gnt_q[i] || grant_now[i]) begin
                starve_d[i] = '0;
            end else if (starve_q[i] != SW'(STARVE_LIM)) begin
                starve_d[i] = starve_q[i] + SW'(1);
            end
        end
    end

    // Wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    assign sel_valid = forced_any || (|elig);
    assign sel_idx   = forced_any ? forced_idx : win_idx;
`else
    assign sel_valid = |elig;
    assign sel_idx   = win_idx;
`endif

    // Grant FSM, round-robin pointer, hold counter and epoch counter
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        bid_lat_d = bid_lat_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        epoch_d   = epoch_wrap ? '0 : (epoch_q + EP_W'(1));
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d   = ST_GRANT;
                    gnt_d     = ONE_HOT0 << sel_idx;
                    gnt_id_d  = sel_idx;
                    bid_lat_d = bid_arr[sel_idx];
                    rr_ptr_d  = (sel_idx == ID_W'(N_REQ - 1)) ? '0 : (sel_idx + ID_W'(1));
                    hold_d    = '0;
                end
            end
            ST_GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                if (done || !req[gnt_id_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            bid_lat_q <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            epoch_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            bid_lat_q <= bid_lat_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            epoch_q   <= epoch_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == ST_GRANT) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_bid_credit_scheduler.sv
// Scoreboard bench for bid_credit_scheduler (default parameters).
// A cycle-level bank/epoch/round-robin model predicts each winner; the expected
// grant is queued when the request is driven and compared when gnt appears.
module tb_bid_credit_scheduler;

    localparam int N_REQ       = 4;
    localparam int EPOCH_LEN   = 400;
    localparam int MAX_HOLD    = 16;
    localparam int STARVE_LIM  = 60;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] bid;
    logic        done;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;

    bid_credit_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .bid    (bid),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    int   m_credit [4];
    int   m_epoch;
    int   m_rr;
    logic m_chg;
    int   m_chg_id;
    int   m_chg_amt;

    logic [3:0] exp_q [$];
    logic [3:0] last_gnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_credit[i] = 750;
        m_epoch = 0;
        m_rr    = 0;
        m_chg   = 1'b0;
    endtask

    // One clock: advance the model exactly as the banks/epoch advance at this edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                int t;
                t = m_credit[i];
                if (m_chg && (m_chg_id == i)) t = (t >= m_chg_amt) ? (t - m_chg_amt) : 0;
                if (m_epoch == EPOCH_LEN - 1) t = t + 750;
                if (t > 900) t = 900;
                m_credit[i] = t;
            end
            m_chg   = 1'b0;
            m_epoch = (m_epoch == EPOCH_LEN - 1) ? 0 : m_epoch + 1;
        end
        #1;
    endtask

    // Expected winner from the model, -1 when nobody is eligible
    function automatic int model_winner(input logic [3:0] r, input logic [15:0] b);
        int best;
        int bv;
        int idx;
        best = 0;
        for (int i = 0; i < 4; i++) begin
            bv = int'(b[i*4 +: 4]);
            if (r[i] && bv != 0 && m_credit[i] >= bv && bv > best) best = bv;
        end
        if (best == 0) return -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_rr + k) % 4;
            bv  = int'(b[idx*4 +: 4]);
            if (r[idx] && m_credit[idx] >= bv && bv == best) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        bid  = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One grant from IDLE. done_after>0: done pulse after that many grant cycles;
    // 0: never done (hold timeout); <0: owner drops req after |done_after| cycles.
    task automatic grant_txn(input int done_after, input string tag);
        int         w;
        int         amt;
        logic [3:0] e;
        w = model_winner(req, bid);
        if (w < 0) begin
            tick();
            chk({tag, "_nogrant"}, 32'(gnt), 32'd0);
            return;
        end
        exp_q.push_back(4'(1 << w));
        m_rr = (w + 1) % 4;
        amt  = int'(bid[w*4 +: 4]);
        tick();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0;
        chk({tag, "_gnt"}, 32'(gnt), 32'(e));
        chk({tag, "_gnt_id"}, 32'(gnt_id), 32'(w));
        chk({tag, "_busy_grant"}, 32'(busy), 32'd1);
        last_gnt = gnt;
        if (done_after > 0) begin
            repeat (done_after - 1) tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end else if (done_after < 0) begin
            repeat (-done_after - 1) tick();
            req[w] = 1'b0;
            tick();
        end else begin
            repeat (MAX_HOLD - 1) tick();
            chk({tag, "_still_held"}, 32'(gnt), 32'(e));
            tick();
        end
        chk({tag, "_rel_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rel_busy"}, 32'(busy), 32'd1);
        m_chg     = 1'b1;
        m_chg_id  = w;
        m_chg_amt = amt;
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bank"}, 32'(dut.credit_all[w]), 32'(m_credit[w]));
        $display("txn %s: owner %0d bid %0d bank %0d", tag, w, amt, dut.credit_all[w]);
    endtask

    logic [3:0] rr_order [5];

    initial begin
        int guard;
        rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
        last_gnt = '0;
        model_reset();

        // Reset state
        rst = 1'b1; req = '0; bid = '0; done = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_bank", 32'(dut.credit_all[i]), 32'd750);
        tick();
        rst = 1'b0;

        // 1: bids 5/9 on masters 0/1, done after 3 cycles
        req = 4'b0011; bid = 16'h0095;
        grant_txn(3, "t1");
        chk("t1_bank1_741", 32'(dut.credit_all[1]), 32'd741);
        req = '0; bid = '0;

        // done outside GRANT is ignored
        done = 1'b1; tick(); done = 1'b0; tick();
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_gnt", 32'(gnt), 32'd0);

        // Owner dropping req releases the grant
        req = 4'b0100; bid = 16'h0300;
        grant_txn(-2, "reqdrop");
        chk("reqdrop_bank2", 32'(dut.credit_all[2]), 32'd747);

        // 4: no done -> 16-cycle hold limit, then 1-cycle release and charge
        req = 4'b1000; bid = 16'h6000;
        grant_txn(0, "t4");
        chk("t4_bank3_744", 32'(dut.credit_all[3]), 32'd744);
        req = '0; bid = '0;

        // 2: equal bids, round-robin order from rr_ptr=0
        do_reset();
        req = 4'b1111; bid = 16'h7777;
        for (int n = 0; n < 5; n++) begin
            grant_txn(2, "t2");
            chk("t2_rr_order", 32'(last_gnt), 32'(rr_order[n]));
        end

        // 6: reset in the middle of a grant
        req = 4'b1010; bid = 16'h7070;
        grant_txn(2, "t6a");
        chk("t6a_gnt1", 32'(last_gnt), 32'd2);
        begin
            int w;
            logic [3:0] e;
            w = model_winner(req, bid);
            exp_q.push_back(4'(1 << w));
            m_rr = (w + 1) % 4;
            tick();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0;
            chk("t6_pre_gnt", 32'(gnt), 32'(e));
            chk("t6_pre_gnt3", 32'(gnt), 32'd8);
        end
        rst = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_id", 32'(gnt_id), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) chk("t6_bank", 32'(dut.credit_all[i]), 32'd750);
        rst = 1'b0;
        grant_txn(2, "t6b");
        chk("t6b_rr0_gnt", 32'(last_gnt), 32'd2);
        req = '0; bid = '0;

        // 3: exhaust bank 0 with bid 15, then refill at the epoch wrap
        do_reset();
        req = 4'b0001; bid = 16'h000F;
        grant_txn(1, "t3");
        chk("t3_bank0_735", 32'(dut.credit_all[0]), 32'd735);
        guard = 0;
        while (m_credit[0] >= 15 && guard < 60) begin
            grant_txn(1, "t3");
            guard++;
        end
        chk("t3_bank0_empty", 32'(dut.credit_all[0]), 32'd0);
`ifdef STARVE_GUARD_EN
        req = 4'b0000;
`endif
        guard = 0;
        while (m_credit[0] < 15 && guard < 450) begin
            tick();
            chk("t3_inelig_gnt", 32'(gnt), 32'd0);
            guard++;
        end
        chk("t3_wrap_seen", 32'(guard < 450), 32'd1);
        chk("t3_refill_bank0", 32'(dut.credit_all[0]), 32'd750);
        chk("t3_sat_bank2", 32'(dut.credit_all[2]), 32'd900);
        req = 4'b0001;
        grant_txn(1, "t3_after");
        chk("t3_after_gnt", 32'(last_gnt), 32'd1);
        req = '0; bid = '0;

`ifdef STARVE_GUARD_EN
        // 5: low bidder is forced through after STARVE_LIM wait cycles
        begin
            int waited;
            int seen;
            do_reset();
            req = 4'b1001; bid = 16'h100F;
            waited = 0; seen = 0;
            for (int c = 0; c < 200 && seen == 0; c++) begin
                if (gnt == 4'b0001) done = 1'b1;
                tick();
                done = 1'b0;
                if (gnt == 4'b1000) seen = 1;
                else waited++;
            end
            chk("t5_m3_served", 32'(seen), 32'd1);
            chk("t5_wait_ge_lim", 32'(waited >= STARVE_LIM), 32'd1);
            $display("txn t5: master 3 granted after %0d cycles", waited);
            do_reset();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
